wallace_final_cpa: RTL and testbench

- Final carry-propagate stage downstream of the 5x5 Wallace tree reduction block.
- Takes the two W-bit partial-sum rows (r1, r2) the tree produces and adds them into the final product.
- The adder is split into two pipeline stages at bit SPLIT to keep the carry chain short.
- Valid/ready handshake on both sides, full throughput (one result per cycle), and a sticky overflow flag that checks the tree's output rows.

---
 rtl/wallace_final_cpa.sv | 135 +++++++++++++
 tb/tb_wallace_final_cpa.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_final_cpa.sv
// Final carry-propagate adder for the 5x5 Wallace tree multiplier.
// Adds the two partial-sum rows in two pipeline stages split at bit SPLIT,
// with a valid/ready handshake on both sides and full throughput.
// A sticky overflow flag reports any row pair whose true sum needs W+1 bits,
// which a correct tree never produces.
module wallace_final_cpa #(
    parameter int W     = 10,
    parameter int SPLIT = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] r1,
    input  logic [W-1:0] r2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] product,
    output logic         ovf
);

    // Width of the upper slice added in stage 2.
    localparam int HW = W - SPLIT;

    // Low slice sum with its carry out in the top bit.
    function automatic logic [SPLIT:0] add_lo(input logic [SPLIT-1:0] a,
                                              input logic [SPLIT-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // High slice sum plus the carry from the low slice; top bit is the
    // carry out of bit W-1.
    function automatic logic [HW:0] add_hi(input logic [HW-1:0] a,
                                           input logic [HW-1:0] b,
                                           input logic          cin);
        return {1'b0, a} + {1'b0, b} + {{HW{1'b0}}, cin};
    endfunction

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [SPLIT-1:0] lo_q, lo_d;
    logic             c_mid_q, c_mid_d;
    logic [HW-1:0]    hi1_q, hi1_d;
    logic [HW-1:0]    hi2_q, hi2_d;

    // Stage 2 (output) state
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     product_q, product_d;
    logic             ovf_q, ovf_d;

    // Handshake terms
    logic             s2_free_s;
    logic             s1_adv_s;
    logic             accept_s;
    logic [SPLIT:0]   lo_sum_s;
    logic [HW:0]      hi_sum_s;

    // Flow control: stage 2 frees when empty or drained this cycle; stage 1
    // frees when empty or advancing. No skid buffer, so in_ready depends
    // combinationally on out_ready.
    always_comb begin
        s2_free_s = !out_valid_q || out_ready;
        s1_adv_s  = s1_valid_q && s2_free_s;
        in_ready  = !s1_valid_q || s1_adv_s;
        accept_s  = in_valid && in_ready;
        lo_sum_s  = add_lo(r1[SPLIT-1:0], r2[SPLIT-1:0]);
        hi_sum_s  = add_hi(hi1_q, hi2_q, c_mid_q);
    end

    // Next-state for stage 1: load on accept (even while advancing), clear
    // when the held pair moves on without a replacement.
    always_comb begin
        s1_valid_d = s1_valid_q;
        lo_d       = lo_q;
        c_mid_d    = c_mid_q;
        hi1_d      = hi1_q;
        hi2_d      = hi2_q;
        if (accept_s) begin
            s1_valid_d = 1'b1;
            lo_d       = lo_sum_s[SPLIT-1:0];
            c_mid_d    = lo_sum_s[SPLIT];
            hi1_d      = r1[W-1:SPLIT];
            hi2_d      = r2[W-1:SPLIT];
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Next-state for stage 2: load the finished sum when stage 1 advances,
    // otherwise drop out_valid once the consumer takes the result.
    always_comb begin
        out_valid_d = out_valid_q;
        product_d   = product_q;
        ovf_d       = ovf_q;
        if (s1_adv_s) begin
            out_valid_d = 1'b1;
            product_d   = {hi_sum_s[HW-1:0], lo_q};
            ovf_d       = ovf_q | hi_sum_s[HW];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            lo_q        <= {SPLIT{1'b0}};
            c_mid_q     <= 1'b0;
            hi1_q       <= {HW{1'b0}};
            hi2_q       <= {HW{1'b0}};
            out_valid_q <= 1'b0;
            product_q   <= {W{1'b0}};
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            lo_q        <= lo_d;
            c_mid_q     <= c_mid_d;
            hi1_q       <= hi1_d;
            hi2_q       <= hi2_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_wallace_final_cpa.sv
// Self-checking bench for wallace_final_cpa: table-driven single
// transactions, then backpressure, streaming, random flow control and
// reset-in-flight sequences, all watched by an in-order scoreboard.
module tb_wallace_final_cpa;

    localparam int W = 10;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] product;
    logic         ovf;

    wallace_final_cpa #(.W(W), .SPLIT(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r1        (r1),
        .r2        (r2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_p;
        logic         exp_ovf;
    } vec_t;

    vec_t         vecs[9];
    int           total;
    int           bad;
    logic [W-1:0] exp_q[$];
    int           out_cnt;
    logic         last_acc;
    logic         hold_prev;
    logic [W-1:0] prev_prod;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle. Mid-cycle (negedge) the handshakes are observed and
    // scored against the reference queue; then step to just after posedge.
    task automatic tick();
        logic [W-1:0] e;
        logic [W:0]   s;
        @(negedge clk);
        last_acc = in_valid && in_ready && !rst;
        if (last_acc) begin
            s = {1'b0, r1} + {1'b0, r2};
            exp_q.push_back(s[W-1:0]);
        end
        if (hold_prev && !rst) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_product", {22'd0, product}, {22'd0, prev_prod});
        end
        if (out_valid && out_ready && !rst) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", {22'd0, product}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard", {22'd0, product}, {22'd0, e});
            end
        end
        hold_prev = out_valid && !out_ready && !rst;
        prev_prod = product;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() != 0) tick();
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic send_one(input vec_t v);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        r1        = v.a;
        r2        = v.b;
        check("vec_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("vec_not_yet_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("vec_out_valid", {31'd0, out_valid}, 32'd1);
        check("vec_product", {22'd0, product}, {22'd0, v.exp_p});
        check("vec_ovf", {31'd0, ovf}, {31'd0, v.exp_ovf});
        tick();
    endtask

    initial begin
        int c0;
        vec_t v;
        total = 0; bad = 0; out_cnt = 0;
        last_acc = 1'b0; hold_prev = 1'b0; prev_prod = '0;

        vecs[0] = '{10'h200, 10'h1C1, 10'h3C1, 1'b0};
        vecs[1] = '{10'h01F, 10'h001, 10'h020, 1'b0};
        vecs[2] = '{10'h0FF, 10'h0FF, 10'h1FE, 1'b0};
        vecs[3] = '{10'h000, 10'h000, 10'h000, 1'b0};
        vecs[4] = '{10'h155, 10'h0AA, 10'h1FF, 1'b0};
        vecs[5] = '{10'h3E0, 10'h01F, 10'h3FF, 1'b0};
        vecs[6] = '{10'h3FF, 10'h001, 10'h000, 1'b1};
        vecs[7] = '{10'h001, 10'h001, 10'h002, 1'b1};
        vecs[8] = '{10'h3FF, 10'h3FF, 10'h3FE, 1'b1};

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; r1 = '0; r2 = '0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_product", {22'd0, product}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Table-driven single transactions (overflow cases last: ovf sticks)
        for (int i = 0; i < 9; i++) send_one(vecs[i]);

        // Reset clears the sticky overflow flag
        rst = 1'b1;
        #1;
        check("rst_clears_ovf", {31'd0, ovf}, 32'd0);
        exp_q.delete(); hold_prev = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Backpressure: two accepted, third blocked, released in order
        out_ready = 1'b0;
        in_valid  = 1'b1; r1 = 10'h003; r2 = 10'h004;
        check("bp_ready_a", {31'd0, in_ready}, 32'd1);
        tick();
        r1 = 10'h010; r2 = 10'h020;
        check("bp_ready_b", {31'd0, in_ready}, 32'd1);
        tick();
        r1 = 10'h100; r2 = 10'h001;
        check("bp_ready_c", {31'd0, in_ready}, 32'd0);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_product", {22'd0, product}, 32'h007);
        tick();
        tick();
        check("bp_ready_c_held", {31'd0, in_ready}, 32'd0);
        check("bp_product_held", {22'd0, product}, 32'h007);
        c0 = out_cnt;
        out_ready = 1'b1;
        #1;
        check("bp_ready_release", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        drain("bp_drain");
        check("bp_count", out_cnt - c0, 32'd3);

        // Streaming: 32 back-to-back pairs, one result per cycle
        tick();
        c0 = out_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            r1 = W'($urandom);
            r2 = W'($urandom);
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("stream_count", out_cnt - c0, 32'd32);
        check("stream_empty", exp_q.size(), 32'd0);

        // Random out_ready toggling; upstream holds data until accepted
        last_acc = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (last_acc || !in_valid) begin
                in_valid = 1'($urandom_range(0, 1));
                r1 = W'($urandom);
                r2 = W'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");

        // Reset mid-flight: two pairs in the pipe, then reset
        out_ready = 1'b0;
        in_valid = 1'b1; r1 = 10'h3FF; r2 = 10'h3FF;
        tick();
        r1 = 10'h011; r2 = 10'h022;
        tick();
        in_valid = 1'b0;
        check("mid_valid_before", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_product", {22'd0, product}, 32'd0);
        check("mid_ovf", {31'd0, ovf}, 32'd0);
        check("mid_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete(); hold_prev = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        c0 = out_cnt;
        for (int i = 0; i < 4; i++) tick();
        check("mid_no_stale", out_cnt - c0, 32'd0);
        check("mid_idle_valid", {31'd0, out_valid}, 32'd0);
        v = '{10'h0AB, 10'h011, 10'h0BC, 1'b0};
        send_one(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
